instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Single-outstanding instruction fetch unit with branch/jump/flush
//            redirect and a registered instruction holding stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        protocol_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;
    logic        perr_q, perr_d;
    logic        started_q, started_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            pc_out_q      <= 32'h0;
            instr_valid_q <= 1'b0;
            perr_q        <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            perr_q        <= perr_d;
            started_q     <= started_d;
        end
    end

    assign w_pc_plus4   = pc_out_q + 32'd4;
    assign w_branch_off = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        perr_d        = perr_q;
        started_d     = 1'b1;

        case (state_q)
            FETCH: begin
                if (imem_rvalid) begin
                    perr_d = 1'b1;
                end
                // The first cycle out of reset issues no request, so nothing is outstanding.
                if (started_q) begin
                    if (flush) begin
                        pc_d    = flush_pc;
                        state_d = DROP;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (flush) begin
                    pc_d = flush_pc;
                end
            end
            WAIT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    pc_out_d      = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (imem_rvalid) begin
                    perr_d = 1'b1;
                end
                if (flush) begin
                    pc_d          = flush_pc;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (!stall) begin
                    pc_d          = w_next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            DROP: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_req     = started_q && (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign op           = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign pc_out       = pc_out_q;
    assign pc_plus4     = w_pc_plus4;
    assign protocol_err = perr_q;

endmodule

`default_nettype wire
